// File: rtl/aes_xts_sector_sequencer.sv
// Sector sequencer between the host register interface and the AES-XTS block engine.
// It walks one data unit through the engine block by block and adds a ciphertext-stealing pass for a partial tail.
module aes_xts_sector_sequencer #(
  parameter int LEN_W         = 13,
  parameter int MAX_LEN_BYTES = 4096,
  parameter int CNT_W         = 9
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inAesMode,
  input  logic             inKeyWr,
  input  logic             inTweakWr,
  input  logic             inStart,
  input  logic [LEN_W-1:0] inLenBytes,
  input  logic             inAbort,
  input  logic             inDataValid,
  input  logic             inEngBusy,
  input  logic             inEngKeysReady,
  output logic             outDataReady,
  output logic             outEngAesMode,
  output logic             outEngKeyWr,
  output logic             outEngTweakWr,
  output logic             outEngDataWr,
  output logic             outEngStealWr,
  output logic [CNT_W-1:0] outEngBlockNr,
  output logic             outEngBlockBeforeLast,
  output logic             outEngLastBlock,
  output logic [3:0]       outTailBytes,
  output logic             outBusy,
  output logic             outDone,
  output logic             outError
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_KEYS, S_READY, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_STEAL, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] nblk_q, nblk_d;
  logic [3:0]       tail_q, tail_d;
  logic             steal_q, steal_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic             len_ok;
  logic [CNT_W-1:0] nblk_calc;
  logic             kill;
  logic             strobe_ok;
  logic             is_last_idx;
  logic             is_before_last_idx;

  assign len_ok    = (inLenBytes >= LEN_W'(16)) && (inLenBytes <= LEN_W'(MAX_LEN_BYTES));
  assign nblk_calc = CNT_W'(inLenBytes >> 4) + CNT_W'(|inLenBytes[3:0]);

  // Abort only matters mid-sector; it and reset both silence every strobe in their cycle.
  assign kill      = inAbort && (state_q != S_IDLE);
  assign strobe_ok = !inRst && !kill;

  assign is_last_idx        = (idx_q == nblk_q - CNT_W'(1));
  assign is_before_last_idx = (idx_q == nblk_q - CNT_W'(2));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    nblk_d  = nblk_q;
    tail_d  = tail_q;
    steal_d = steal_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (kill) begin
      state_d = S_IDLE;
      idx_d   = '0;
      nblk_d  = '0;
      tail_d  = '0;
      steal_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      if (inStart && (state_q != S_IDLE)) err_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (inStart) begin
            if (len_ok) begin
              state_d = S_WAIT_KEYS;
              mode_d  = inAesMode;
              nblk_d  = nblk_calc;
              tail_d  = inLenBytes[3:0];
              idx_d   = '0;
              steal_d = 1'b0;
              last_d  = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_WAIT_KEYS: if (inEngKeysReady) state_d = S_READY;
        S_READY:     if (outDataReady && inDataValid) state_d = S_ISSUE;
        S_ISSUE: begin
          // idx parks on the final block; last_q records that it has gone out.
          if (is_last_idx) last_d = 1'b1;
          else             idx_d  = idx_q + CNT_W'(1);
          state_d = S_WAIT_HI;
        end
        S_WAIT_HI:   if (inEngBusy) state_d = S_WAIT_LO;
        S_WAIT_LO: begin
          if (!inEngBusy) begin
            if (!last_q)                         state_d = S_READY;
            else if ((tail_q != 4'd0) && !steal_q) state_d = S_STEAL;
            else                                 state_d = S_DONE;
          end
        end
        S_STEAL: begin
          steal_d = 1'b1;
          state_d = S_WAIT_HI;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      nblk_q  <= '0;
      tail_q  <= '0;
      steal_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      nblk_q  <= nblk_d;
      tail_q  <= tail_d;
      steal_q <= steal_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    outBusy       = (state_q != S_IDLE);
    outEngAesMode = outBusy ? mode_q : inAesMode;
    outEngKeyWr   = inKeyWr && (state_q == S_IDLE) && !inRst;
    outEngTweakWr = inTweakWr && strobe_ok &&
                    ((state_q == S_IDLE) || (state_q == S_WAIT_KEYS) ||
                     ((state_q == S_READY) && (idx_q == '0) && !last_q));
    outDataReady  = (state_q == S_READY) && inEngKeysReady && !inEngBusy && strobe_ok;
    outEngDataWr  = (state_q == S_ISSUE) && strobe_ok;
    outEngStealWr = (state_q == S_STEAL) && strobe_ok;
    outEngBlockNr = idx_q;
    outEngLastBlock       = outEngDataWr && is_last_idx;
    outEngBlockBeforeLast = outEngDataWr && (tail_q != 4'd0) && is_before_last_idx;
    outTailBytes  = tail_q;
    outDone       = (state_q == S_DONE) && strobe_ok;
    outError      = err_q;
  end

endmodule

// File: doc/aes_xts_sector_sequencer.md
Name: aes_xts_sector_sequencer

Overview:
- Parametrised sequencer between the host-side register interface and the AES-XTS block engine.
- Runs one complete data unit (sector) of 16..MAX_LEN_BYTES bytes through the engine, one 128-bit block at a time.
- Gates key and tweak writes, generates block numbers and the before-last/last flags, and issues the ciphertext-stealing pass for a partial tail.
- Adds abort, length checking and done/error status.

Parameters:
- LEN_W, 13, width of the sector byte-length input.
- MAX_LEN_BYTES, 4096, largest legal sector length in bytes; must be < 2^LEN_W.
- CNT_W, 9, block-index width; must satisfy 2^CNT_W >= ceil(MAX_LEN_BYTES/16).

Ports:
- inClk  in  1  clock; all logic on rising edge.
- inRst  in  1  synchronous active-high reset.
- inAesMode  in  1  0=encrypt, 1=decrypt; sampled with inStart.
- inKeyWr  in  1  host key-write strobe.
- inTweakWr  in  1  host tweak-write strobe.
- inStart  in  1  start-sector pulse.
- inLenBytes  in  LEN_W  sector length in bytes; sampled with inStart.
- inAbort  in  1  abort current sector.
- inDataValid  in  1  host has a 128-bit block in the engine input register.
- inEngBusy  in  1  engine busy.
- inEngKeysReady  in  1  engine key schedule valid.
- outDataReady  out  1  block accepted this cycle if inDataValid=1.
- outEngAesMode  out  1  mode to engine.
- outEngKeyWr  out  1  gated key write.
- outEngTweakWr  out  1  gated tweak write.
- outEngDataWr  out  1  one-cycle block-issue pulse.
- outEngStealWr  out  1  one-cycle ciphertext-stealing pass pulse.
- outEngBlockNr  out  CNT_W  index of the block being issued.
- outEngBlockBeforeLast  out  1  qualifies outEngDataWr.
- outEngLastBlock  out  1  qualifies outEngDataWr.
- outTailBytes  out  4  inLenBytes[3:0] latched; 0 = no stealing.
- outBusy  out  1  sector in progress.
- outDone  out  1  one-cycle sector-complete pulse.
- outError  out  1  one-cycle illegal-length or illegal-start pulse.

Behaviour:
- Reset values: state IDLE; all outputs 0; internal registers cleared.
- States and transitions:
  - IDLE: on inStart go to WAIT_KEYS.
  - WAIT_KEYS: wait for inEngKeysReady=1, then go to READY.
  - READY: handshake accepts a block, go to ISSUE.
  - ISSUE: lasts 1 cycle, go to WAIT_HI.
  - WAIT_HI: wait for inEngBusy=1, then go to WAIT_LO.
  - WAIT_LO: wait for inEngBusy=0.
    - If blocks remain: go to READY.
    - Else if tail!=0 and no steal done yet: go to STEAL.
    - Else: go to DONE.
  - STEAL: lasts 1 cycle, outEngStealWr=1, go to WAIT_HI with the steal flag set.
  - DONE: lasts 1 cycle, outDone=1, go to IDLE.
- Start: accepted only in IDLE.
  - Latch mode, nBlocks=ceil(len/16) and tail=len[3:0].
  - If len<16 or len>MAX_LEN_BYTES: outError=1 for one cycle; stay IDLE.
  - inStart outside IDLE: outError=1; ignored otherwise.
- Key writes: outEngKeyWr=inKeyWr only in IDLE, else 0.
- Tweak writes: outEngTweakWr=inTweakWr only in IDLE or WAIT_KEYS, or in READY before block 0 is issued; else 0.
- outEngAesMode: driven from the latched mode while outBusy=1; from inAesMode in IDLE.
- Data handshake:
  - outDataReady=1 only in READY, with inEngKeysReady=1 and inEngBusy=0.
  - Transfer occurs when outDataReady and inDataValid are both 1.
  - In ISSUE: outEngDataWr=1 with outEngBlockNr=idx.
  - outEngLastBlock=(idx==nBlocks-1).
  - outEngBlockBeforeLast=(tail!=0 and idx==nBlocks-2).
  - idx increments on leaving ISSUE.
  - No wrap: idx never exceeds nBlocks-1.
- Keys dropping: if inEngKeysReady falls while in READY, stay in READY with outDataReady=0.
- Busy already high: if inEngBusy is already 1 in the ISSUE cycle, WAIT_HI exits on the next cycle.
- outBusy=1 in every state except IDLE.
- Abort: inAbort in any state except IDLE forces IDLE next cycle.
  - Clears idx, nBlocks, tail and the steal flag.
  - No outDone.
  - Any strobe pending that cycle is suppressed.
  - Abort has priority over simultaneous inStart/handshake.
- Reset: inRst has priority over everything. Mid-sector reset behaves like abort but also clears outError.
- Latency:
  - Start to READY: ≥2 cycles.
  - Handshake to outEngDataWr: 1 cycle.
  - Last engine busy-low to outDone: 1 cycle, or via STEAL when tail!=0.

Test Plan:
- Length 512, keys ready, engine busy 20 cycles per block -> 32 DataWr pulses, BlockNr 0..31; LastBlock only on 31; BeforeLast never; no StealWr; one outDone.
- Length 40 -> 3 blocks; BeforeLast on BlockNr 1; LastBlock on BlockNr 2; outTailBytes=8; exactly one StealWr after block 2 completes; then outDone.
- Lengths 15 and 4097 -> outError pulse, outBusy stays 0; inKeyWr mid-sector -> outEngKeyWr stays 0; inKeyWr in IDLE -> passed through.
- inAbort while in WAIT_LO on block 5 of 32 -> IDLE next cycle, no outDone; a fresh start of length 16 issues BlockNr 0 with LastBlock=1.
- inRst asserted in STEAL -> all outputs 0 next cycle; inEngKeysReady low for 10 cycles after start -> outDataReady held 0 until it rises.
